// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: snapshots per-digit values once per
// frame and drives shared segment lines plus one anode per digit, with blanking and PWM.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_enable,
  input  logic [3:0]              brightness,
  input  logic [4*NUM_DIGITS-1:0] digit_value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   digit_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = ((PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          slot_cnt_q, slot_cnt_d;
  logic [3:0]                pwm_cnt_q, pwm_cnt_d;
  logic [4*NUM_DIGITS-1:0]   sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]     sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [3:0]                sh_bright_q, sh_bright_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_done_q, frame_done_d;
  logic                      load_shadow;
  logic [3:0]                digit_nib;
  logic [NUM_DIGITS-1:0]     an_act;

  function automatic logic [6:0] decode_hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      slot_cnt_q   <= '0;
      pwm_cnt_q    <= '0;
      sh_value_q   <= '0;
      sh_en_q      <= '0;
      sh_dp_q      <= '0;
      sh_bright_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= ACTIVE_LOW;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      slot_cnt_q   <= slot_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      sh_value_q   <= sh_value_d;
      sh_en_q      <= sh_en_d;
      sh_dp_q      <= sh_dp_d;
      sh_bright_q  <= sh_bright_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sequencing; counters describe the cycle the registered outputs will show next.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_cnt_d   = slot_cnt_q;
    pwm_cnt_d    = pwm_cnt_q;
    frame_done_d = 1'b0;
    load_shadow  = 1'b0;

    if (!cfg_enable) begin
      state_d    = IDLE;
      idx_d      = '0;
      slot_cnt_d = '0;
      pwm_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = '0;
          slot_cnt_d  = '0;
          pwm_cnt_d   = '0;
          load_shadow = 1'b1;
        end
        BLANK: begin
          if (slot_cnt_q == BLANK_LAST) begin
            state_d    = SHOW;
            slot_cnt_d = '0;
            pwm_cnt_d  = '0;
          end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (slot_cnt_q == SHOW_LAST) begin
            state_d    = BLANK;
            slot_cnt_d = '0;
            pwm_cnt_d  = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              load_shadow  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
            pwm_cnt_d  = pwm_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sh_value_d  = sh_value_q;
    sh_en_d     = sh_en_q;
    sh_dp_d     = sh_dp_q;
    sh_bright_d = sh_bright_q;
    if (load_shadow) begin
      sh_value_d  = digit_value;
      sh_en_d     = digit_en;
      sh_dp_d     = digit_dp;
      sh_bright_d = brightness;
    end
  end

  // Shadow values never change on entry to SHOW, so the _q copies are safe to decode here.
  always_comb begin
    seg_d     = seg_q;
    dp_d      = dp_q;
    an_d      = AN_OFF;
    an_act    = '0;
    digit_nib = sh_value_q[4*int'(idx_d) +: 4];
    case (state_d)
      SHOW: begin
        seg_d = decode_hex(digit_nib) ^ SEG_OFF;
        dp_d  = sh_dp_q[int'(idx_d)] ^ ACTIVE_LOW;
        if (sh_en_q[int'(idx_d)] && (pwm_cnt_d <= sh_bright_q)) begin
          an_act[int'(idx_d)] = 1'b1;
        end
        an_d = an_act ^ AN_OFF;
      end
      BLANK: begin
        seg_d = seg_q;
        dp_d  = dp_q;
      end
      default: begin
        seg_d = SEG_OFF;
        dp_d  = ACTIVE_LOW;
      end
    endcase
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
